alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_iter_muldiv.sv | 91 +++++++++
 rtl/alu_multicycle.sv | 127 ++++++++++++
 tb/tb_alu_multicycle.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and opcode classification for the multicycle ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_REMU = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial shift-add multiplier and restoring divider, one bit per cycle.
// Operands load on start; done is high during the last iteration and result
// then carries the value that the final step produces. A zero divisor falls
// out naturally as quotient all ones and remainder equal to the dividend.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [3:0]       op_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo, divisor;

   logic [WIDTH-1:0] acc_nxt, quo_nxt;
   logic [WIDTH:0]   rem_sh, rem_diff, rem_nxt;

   // One multiply step and one restoring-divide step, computed every cycle.
   always_comb begin
      acc_nxt  = acc + (mplier[0] ? mcand : '0);
      rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, divisor};
      quo_nxt  = {quo[WIDTH-2:0], ~rem_diff[WIDTH]};
      rem_nxt  = rem_diff[WIDTH] ? rem_sh : rem_diff;
   end

   assign done = busy && (cnt == CNT_LAST);

   // Select the finishing value for the latched operation.
   always_comb begin
      result = '0;
      case (op_q)
         OP_MUL:  result = acc_nxt;
         OP_DIVU: result = quo_nxt;
         OP_REMU: result = rem_nxt[WIDTH-1:0];
         default: result = '0;
      endcase
   end

   // Iteration state: load on start, advance one bit per busy cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         cnt     <= '0;
         op_q    <= OP_AND;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
      end else if (start) begin
         busy    <= 1'b1;
         cnt     <= '0;
         op_q    <= op;
         acc     <= '0;
         mcand   <= a;
         mplier  <= b;
         rem     <= '0;
         quo     <= a;
         divisor <= b;
      end else if (busy) begin
         acc    <= acc_nxt;
         mcand  <= {mcand[WIDTH-2:0], 1'b0};
         mplier <= {1'b0, mplier[WIDTH-1:1]};
         rem    <= rem_nxt;
         quo    <= quo_nxt;
         cnt    <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes. Single-cycle ops register their
// result on the accept edge; MUL/DIVU/REMU run through the bit-serial unit.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | bit-serial mul/div iterating
// DONE  | result held until consumer takes it
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             overflow_o
);

   state_t state, state_nxt;

   logic             accept, start_iter, load_single, load_iter;
   logic             iter_busy, iter_done;
   logic [WIDTH-1:0] iter_res;
   logic [WIDTH-1:0] sum, dif;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   assign ready_o = (state == ST_IDLE);
   assign valid_o = (state == ST_DONE);
   assign zero_o  = (result_o == '0);
   assign accept  = valid_i && ready_o;
   assign sum     = src1_i + src2_i;
   assign dif     = src1_i - src2_i;

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk_i),
      .rst    (rst_i),
      .start  (start_iter),
      .op     (ctrl_i),
      .a      (src1_i),
      .b      (src2_i),
      .busy   (iter_busy),
      .done   (iter_done),
      .result (iter_res)
   );

   // Single-cycle datapath; unknown opcodes yield zero.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (ctrl_i)
         OP_AND: alu_res = src1_i & src2_i;
         OP_OR:  alu_res = src1_i | src2_i;
         OP_NOR: alu_res = ~(src1_i | src2_i);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = dif;
            alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (dif[WIDTH-1] != src1_i[WIDTH-1]);
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
         default: alu_res = '0;
      endcase
   end

   // Next-state and load strobes.
   always_comb begin
      state_nxt   = state;
      start_iter  = 1'b0;
      load_single = 1'b0;
      load_iter   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_multicycle(ctrl_i)) begin
                  start_iter = 1'b1;
                  state_nxt  = ST_BUSY;
               end else begin
                  load_single = 1'b1;
                  state_nxt   = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
            if (iter_done) begin
               load_iter = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (ready_i) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Result registers, held while DONE waits for the consumer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_o   <= '0;
         overflow_o <= 1'b0;
      end else if (load_single) begin
         result_o   <= alu_res;
         overflow_o <= alu_ovf;
      end else if (load_iter) begin
         result_o   <= iter_res;
         overflow_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 with hand-computed expectations.
module tb_alu_multicycle;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [3:0]  ctrl_i = 4'h0;
   logic [31:0] src1_i = '0;
   logic [31:0] src2_i = '0;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [31:0] result_o;
   logic        zero_o;
   logic        overflow_o;

   int n_chk = 0;
   int n_bad = 0;

   alu_multicycle #(.WIDTH(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .ctrl_i     (ctrl_i),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .result_o   (result_o),
      .zero_o     (zero_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request, scramble the inputs after accept, wait for valid_o,
   // check the outcome, optionally hold off the consumer, then hand-shake.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_ovf, input int exp_lat, input int hold);
      int          lat;
      logic        rdy_seen;
      logic        unstable;
      logic [31:0] held;
      @(negedge clk_i);
      check({tag, "_ready_pre"}, ready_o, 1'b1);
      valid_i = 1'b1;
      ctrl_i  = op;
      src1_i  = a;
      src2_i  = b;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      ctrl_i  = 4'(op + 4'd1);
      src1_i  = $urandom;
      src2_i  = $urandom;
      lat      = 0;
      rdy_seen = 1'b0;
      while (lat < 100) begin
         @(negedge clk_i);
         lat++;
         if (valid_o) break;
         if (ready_o) rdy_seen = 1'b1;
         valid_i = 1'($urandom_range(0, 1));
         src1_i  = $urandom;
      end
      valid_i = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, result_o, exp_res);
      check({tag, "_zero"}, zero_o, (exp_res == 32'h0));
      check({tag, "_ovf"}, overflow_o, exp_ovf);
      if (exp_lat > 1) check({tag, "_ready_busy"}, rdy_seen, 1'b0);
      if (hold > 0) begin
         held     = result_o;
         unstable = 1'b0;
         repeat (hold) begin
            @(negedge clk_i);
            if (result_o !== held || valid_o !== 1'b1 || ready_o !== 1'b0) unstable = 1'b1;
         end
         check({tag, "_hold"}, unstable, 1'b0);
      end
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      check({tag, "_valid_after"}, valid_o, 1'b0);
      check({tag, "_ready_after"}, ready_o, 1'b1);
   endtask

   initial begin
      logic stale;
      repeat (3) @(negedge clk_i);
      check("rst_valid", valid_o, 1'b0);
      check("rst_result", result_o, 32'h0);
      check("rst_zero", zero_o, 1'b1);
      check("rst_ovf", overflow_o, 1'b0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_ready", ready_o, 1'b1);

      run_op("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1, 0);
      run_op("sub_zero", 4'b0110, 32'd5,        32'd5,        32'h00000000, 1'b0, 1, 0);
      run_op("slt",      4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 0);
      run_op("slt_neg",  4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 0);
      run_op("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1, 0);
      run_op("or",       4'b0001, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0, 1, 0);
      run_op("nor",      4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1, 0);
      run_op("sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1, 0);
      run_op("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 0);
      run_op("illegal",  4'b0011, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0, 1, 0);
      run_op("mul",      4'b1000, 32'h00010003, 32'h00000005, 32'h0005000F, 1'b0, 33, 3);
      run_op("divu",     4'b1001, 32'd100,      32'd7,        32'd14,       1'b0, 33, 0);
      run_op("remu",     4'b1010, 32'd100,      32'd7,        32'd2,        1'b0, 33, 0);
      run_op("divu_z",   4'b1001, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33, 0);
      run_op("remu_z",   4'b1010, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 33, 0);

      // Abort a MUL mid-iteration; the prior nonzero result must be cleared.
      @(negedge clk_i);
      valid_i = 1'b1;
      ctrl_i  = 4'b1000;
      src1_i  = 32'h00010003;
      src2_i  = 32'h00000005;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      repeat (10) @(negedge clk_i);
      check("abort_busy", ready_o, 1'b0);
      #2 rst_i = 1'b1;
      #1;
      check("abort_valid", valid_o, 1'b0);
      check("abort_result", result_o, 32'h0);
      check("abort_zero", zero_o, 1'b1);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("abort_ready", ready_o, 1'b1);
      stale = 1'b0;
      repeat (40) begin
         @(negedge clk_i);
         if (valid_o || result_o != 32'h0) stale = 1'b1;
      end
      check("abort_stale", stale, 1'b0);

      run_op("post_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
